// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA/DVI raster timing generator. Produces pixel coordinates,
//   registered hsync/vsync/de and combinational line/frame strobes. The raster
//   advances one pixel per clk edge on which ce is high, so the block can run
//   from a system clock faster than the pixel rate.
//
//   Optional feature: define VGA_SYNC_DELAY_EN to pass hsync, vsync and de
//   through a SYNC_DELAY-stage shift register (advancing on ce) so they line
//   up with a downstream pixel pipeline. sx, sy and the strobes are never
//   delayed.
//
// Ports
//   clk          in   pixel/system clock
//   reset        in   synchronous, active-high reset
//   ce           in   pixel enable
//   sx, sy       out  CW-bit raster position (0..H_ACTIVE-1 / 0..V_ACTIVE-1 active)
//   hsync, vsync out  sync outputs, active level H_POL / V_POL
//   de           out  data enable, high only in the active region
//   line_start   out  ce && sx==0 (never during reset)
//   frame_start  out  ce && sx==0 && sy==0 (never during reset)
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int CW         = 10,
  parameter int SYNC_DELAY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_STA  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_STA + H_SYNC;
  localparam int VS_STA  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_STA + V_SYNC;

  localparam logic [CW-1:0] H_MAX = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX = CW'(V_TOTAL - 1);

  // Region bounds carry one extra bit: HS_END/VS_END may equal the total,
  // which need not fit in CW bits.
  localparam logic [CW:0] H_ACT_B  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] V_ACT_B  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] HS_STA_B = (CW+1)'(HS_STA);
  localparam logic [CW:0] HS_END_B = (CW+1)'(HS_END);
  localparam logic [CW:0] VS_STA_B = (CW+1)'(VS_STA);
  localparam logic [CW:0] VS_END_B = (CW+1)'(VS_END);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  logic [CW-1:0] sx_r, sy_r;
  logic [CW-1:0] sx_nxt, sy_nxt;
  logic          hs_r, vs_r, de_r;
  logic          hs_nxt, vs_nxt, de_nxt;

  // Next raster position and the sync/de levels that belong to it. The
  // registers below load both together so hsync/vsync/de always describe the
  // sx/sy presented in the same cycle.
  always_comb begin
    sx_nxt = sx_r + 1'b1;
    sy_nxt = sy_r;
    if (sx_r == H_MAX) begin
      sx_nxt = '0;
      if (sy_r == V_MAX) begin
        sy_nxt = '0;
      end else begin
        sy_nxt = sy_r + 1'b1;
      end
    end
    hs_nxt = (({1'b0, sx_nxt} >= HS_STA_B) && ({1'b0, sx_nxt} < HS_END_B)) ? HS_ON : ~HS_ON;
    vs_nxt = (({1'b0, sy_nxt} >= VS_STA_B) && ({1'b0, sy_nxt} < VS_END_B)) ? VS_ON : ~VS_ON;
    de_nxt = ({1'b0, sx_nxt} < H_ACT_B) && ({1'b0, sy_nxt} < V_ACT_B);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sx_r <= '0;
      sy_r <= '0;
      hs_r <= ~HS_ON;
      vs_r <= ~VS_ON;
      de_r <= 1'b1;   // position 0,0 is inside the active region
    end else if (ce) begin
      sx_r <= sx_nxt;
      sy_r <= sy_nxt;
      hs_r <= hs_nxt;
      vs_r <= vs_nxt;
      de_r <= de_nxt;
    end
  end

  assign sx = sx_r;
  assign sy = sy_r;

  // Strobes follow the current position and ce; reset masks them.
  assign line_start  = ce && !reset && (sx_r == '0);
  assign frame_start = ce && !reset && (sx_r == '0) && (sy_r == '0);

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_pipe, vs_pipe, de_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_pipe <= {SYNC_DELAY{~HS_ON}};
      vs_pipe <= {SYNC_DELAY{~VS_ON}};
      de_pipe <= '0;
    end else if (ce) begin
      hs_pipe[0] <= hs_r;
      vs_pipe[0] <= vs_r;
      de_pipe[0] <= de_r;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        de_pipe[i] <= de_pipe[i-1];
      end
    end
  end

  assign hsync = hs_pipe[SYNC_DELAY-1];
  assign vsync = vs_pipe[SYNC_DELAY-1];
  assign de    = de_pipe[SYNC_DELAY-1];
`else
  // SYNC_DELAY has no effect in this build.
  logic unused_sync_delay;
  assign unused_sync_delay = (SYNC_DELAY != 0);

  assign hsync = hs_r;
  assign vsync = vs_r;
  assign de    = de_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // Tiny raster: H_TOTAL = 8, V_TOTAL = 6, frame = 48 ce pulses.
  localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int HSS = HA + HF, HSE = HA + HF + HSW;
  localparam int VSS = VA + VF, VSE = VA + VF + VSW;
  localparam int DLY = 2;

  logic clk = 1'b0;
  logic reset, ce;

  logic [3:0] a_sx, a_sy, b_sx, b_sy;
  logic a_hs, a_vs, a_de, a_ls, a_fs;
  logic b_hs, b_vs, b_de, b_ls, b_fs;

  int n_cmp = 0;
  int n_bad = 0;
  int p = 0;   // ce steps taken since the last reset

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .H_POL(0), .V_POL(0), .CW(4), .SYNC_DELAY(DLY)
  ) dut_a (
    .clk(clk), .reset(reset), .ce(ce), .sx(a_sx), .sy(a_sy),
    .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .H_POL(1), .V_POL(1), .CW(4), .SYNC_DELAY(DLY)
  ) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .sx(b_sx), .sy(b_sy),
    .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .line_start(b_ls), .frame_start(b_fs)
  );

  // ---------------- reference model ----------------
  // Ideal {hsync, vsync, de} for the raster position reached after q ce steps.
  function automatic logic [2:0] ideal(int q, logic pol);
    int x, y;
    logic hs, vs, de;
    x  = q % HT;
    y  = (q / HT) % VT;
    hs = (x >= HSS && x < HSE) ? pol : !pol;
    vs = (y >= VSS && y < VSE) ? pol : !pol;
    de = (x < HA) && (y < VA);
    return {hs, vs, de};
  endfunction

  function automatic logic [2:0] expect_out(int q, logic pol);
`ifdef VGA_SYNC_DELAY_EN
    if (q < DLY) return {!pol, !pol, 1'b0};
    return ideal(q - DLY, pol);
`else
    return ideal(q, pol);
`endif
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic c);
    @(negedge clk);
    reset = r;
    ce    = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) p = 0;
    else if (ce) p++;
  endtask

  task automatic check_model();
    logic [2:0] ea, eb;
    logic ls_e, fs_e;
    ea   = expect_out(p, 1'b0);
    eb   = expect_out(p, 1'b1);
    ls_e = ce && !reset && ((p % HT) == 0);
    fs_e = ce && !reset && ((p % (HT * VT)) == 0);
    check("a_sx", a_sx, p % HT);
    check("a_sy", a_sy, (p / HT) % VT);
    check("a_hsync", a_hs, ea[2]);
    check("a_vsync", a_vs, ea[1]);
    check("a_de", a_de, ea[0]);
    check("a_line_start", a_ls, ls_e);
    check("a_frame_start", a_fs, fs_e);
    check("b_sx", b_sx, p % HT);
    check("b_sy", b_sy, (p / HT) % VT);
    check("b_hsync", b_hs, eb[2]);
    check("b_vsync", b_vs, eb[1]);
    check("b_de", b_de, eb[0]);
  endtask

  // ---------------- directed vector table ----------------
  // Inputs are applied, the outputs (state from the previous edge plus
  // strobes from the new inputs) are checked, then the edge happens.
  typedef struct packed {
    logic       r;
    logic       c;
    logic [3:0] sx;
    logic [3:0] sy;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } vec_t;

  vec_t tbl [0:14];

  int fs_cnt, last_fs;
  logic prev_ls;

  initial begin
    reset = 1'b1;
    ce    = 1'b0;

    tbl[0]  = '{r:1, c:1, sx:0, sy:0, de:1, hs:1, vs:1, ls:0, fs:0};  // reset beats ce
    tbl[1]  = '{r:0, c:0, sx:0, sy:0, de:1, hs:1, vs:1, ls:0, fs:0};  // ce low: no strobe
    tbl[2]  = '{r:0, c:1, sx:0, sy:0, de:1, hs:1, vs:1, ls:1, fs:1};
    tbl[3]  = '{r:0, c:0, sx:1, sy:0, de:1, hs:1, vs:1, ls:0, fs:0};
    tbl[4]  = '{r:0, c:1, sx:1, sy:0, de:1, hs:1, vs:1, ls:0, fs:0};  // held through ce=0
    tbl[5]  = '{r:0, c:1, sx:2, sy:0, de:1, hs:1, vs:1, ls:0, fs:0};
    tbl[6]  = '{r:0, c:1, sx:3, sy:0, de:1, hs:1, vs:1, ls:0, fs:0};
    tbl[7]  = '{r:0, c:1, sx:4, sy:0, de:0, hs:1, vs:1, ls:0, fs:0};  // de falls at H_ACTIVE
    tbl[8]  = '{r:0, c:1, sx:5, sy:0, de:0, hs:0, vs:1, ls:0, fs:0};  // hsync starts
    tbl[9]  = '{r:0, c:0, sx:6, sy:0, de:0, hs:0, vs:1, ls:0, fs:0};
    tbl[10] = '{r:0, c:1, sx:6, sy:0, de:0, hs:0, vs:1, ls:0, fs:0};
    tbl[11] = '{r:0, c:1, sx:7, sy:0, de:0, hs:1, vs:1, ls:0, fs:0};  // hsync ended
    tbl[12] = '{r:0, c:1, sx:0, sy:1, de:1, hs:1, vs:1, ls:1, fs:0};  // wrapped to new line
    tbl[13] = '{r:1, c:1, sx:1, sy:1, de:1, hs:1, vs:1, ls:0, fs:0};  // mid-frame reset
    tbl[14] = '{r:0, c:1, sx:0, sy:0, de:1, hs:1, vs:1, ls:1, fs:1};  // clean restart

    drive(1'b1, 1'b0);
    tick();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].r, tbl[i].c);
      check($sformatf("tbl%0d_sx", i), a_sx, tbl[i].sx);
      check($sformatf("tbl%0d_sy", i), a_sy, tbl[i].sy);
      check($sformatf("tbl%0d_vsync", i), a_vs, tbl[i].vs);
      check($sformatf("tbl%0d_line_start", i), a_ls, tbl[i].ls);
      check($sformatf("tbl%0d_frame_start", i), a_fs, tbl[i].fs);
`ifndef VGA_SYNC_DELAY_EN
      check($sformatf("tbl%0d_de", i), a_de, tbl[i].de);
      check($sformatf("tbl%0d_hsync", i), a_hs, tbl[i].hs);
`endif
      tick();
    end

    // ce held high: frame_start every 48 clks.
    drive(1'b1, 1'b1);
    tick();
    fs_cnt  = 0;
    last_fs = -1;
    for (int i = 0; i < 130; i++) begin
      drive(1'b0, 1'b1);
      check_model();
      if (a_fs === 1'b1) begin
        if (last_fs >= 0) check("fs_period_ce1", i - last_fs, HT * VT);
        last_fs = i;
        fs_cnt++;
      end
      tick();
    end
    check("fs_count_ce1", fs_cnt, 3);

    // ce every other clk: frame_start every 96 clks, line_start one clk wide.
    drive(1'b1, 1'b1);
    tick();
    fs_cnt  = 0;
    last_fs = -1;
    prev_ls = 1'b0;
    for (int i = 0; i < 250; i++) begin
      drive(1'b0, (i % 2) == 0);
      check_model();
      check("ls_single_clk", prev_ls && a_ls, 0);
      prev_ls = a_ls;
      if (a_fs === 1'b1) begin
        if (last_fs >= 0) check("fs_period_ce_half", i - last_fs, 2 * HT * VT);
        last_fs = i;
        fs_cnt++;
      end
      tick();
    end
    check("fs_count_ce_half", fs_cnt, 3);

    // Random ce and occasional reset against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0);
      check_model();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
